microwave_ctrl_param: RTL

Parametrised next-generation microwave controller. Takes one-hot keypad digit entry into a configurable-width BCD time display (mm..m:ss) and counts down at 1 Hz from a prescaled clock. Adds pause/resume, door interlock and power-level duty cycling of the magnetron. Sits between the debounced front-panel inputs and the display/magnetron drivers.

---
 rtl/mw_pkg.sv | 46 ++++
 rtl/microwave_ctrl_param_seg7.sv | 14 +
 rtl/microwave_ctrl_param.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mw_pkg.sv
// mw_pkg: shared definitions for the microwave controller.
//   - FSM state encoding (3-bit codes IDLE..DONE)
//   - BCD digit width and the seconds-tens wrap value
//   - 7-segment codes (bit 0 = a ... bit 6 = g, active-high) and a decode helper
package mw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } mw_state_t;

    localparam int         BCD_W         = 4;
    localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/microwave_ctrl_param_seg7.sv
// mw_seg7: one BCD digit to active-high a..g segments; codes 10-15 blank.
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  segments, bit 0 = a ... bit 6 = g
module mw_seg7
    import mw_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/microwave_ctrl_param.sv
// microwave_ctrl_param: keypad time entry, 1 Hz BCD countdown, pause/resume,
// door interlock and per-second power duty cycling of the magnetron.
// Optional build macro: MW_SEG_DECODE_EN builds one mw_seg7 per digit to drive
// seg; without it seg is tied to zero.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   keypad[9:0]      one-hot digit keys
//   startn/stopn/clearn  active-low buttons (level, edge-detected here)
//   door_closed      1 = door closed
//   power_sel[3:0]   power level, 0 or > POWER_LEVELS = full power
//   digits           packed BCD time, digit 0 in LSBs
//   seg              7-segment per digit
//   state            FSM state code
//   magnetron_on     heating enable (gated live by door_closed)
//   timer_done       high while in DONE
module microwave_ctrl_param
    import mw_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int TICKS_PER_SEC = 100,
    parameter int POWER_LEVELS  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                keypad,
    input  logic                      startn,
    input  logic                      stopn,
    input  logic                      clearn,
    input  logic                      door_closed,
    input  logic [3:0]                power_sel,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic [7*NUM_DIGITS-1:0]   seg,
    output logic [2:0]                state,
    output logic                      magnetron_on,
    output logic                      timer_done
);

    localparam int             DW         = BCD_W * NUM_DIGITS;
    localparam int             TW         = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0]  PRESC_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]     WIN_LAST   = 4'(POWER_LEVELS - 1);
    localparam logic [3:0]     PWR_MAX    = 4'(POWER_LEVELS);

    mw_state_t       state_reg;
    logic [DW-1:0]   digits_reg;
    logic [TW-1:0]   presc_reg;
    logic [3:0]      win_reg;
    logic [3:0]      power_reg;
    logic            timer_done_reg;
    logic            mag_term_reg;

    logic            start_prev_reg, stop_prev_reg, clear_prev_reg;
    logic [9:0]      key_prev_reg;
    logic            start_press_reg, stop_press_reg, clear_press_reg, key_press_reg;
    logic [3:0]      key_val_reg;

    logic            key_single;
    logic [3:0]      key_val;
    logic            ev_clear, ev_stop, ev_start, ev_key, any_press;
    logic            tick;
    logic [DW-1:0]   digits_dec;
    logic [DW-1:0]   digits_shift;
    logic [3:0]      win_inc;
    logic            full_power;

    // One-second decrement: ones and minute digits borrow base-10, the
    // seconds-tens digit wraps 0 -> 5. Entered tens values 6-9 just count down.
    function automatic logic [DW-1:0] dec_time(input logic [DW-1:0] t);
        logic [DW-1:0] r;
        logic          borrow;
        logic [3:0]    d;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = t[i*BCD_W +: BCD_W];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = (i == 1) ? SEC_TENS_WRAP : 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[i*BCD_W +: BCD_W] = d;
        end
        return r;
    endfunction

    function automatic logic duty_on(input logic [3:0] w, input logic [3:0] p, input logic full);
        return full || (w < p);
    endfunction

    // Keypad: exactly one bit set; value is the index of that bit.
    assign key_single = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
    always_comb begin
        key_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_val = 4'(i);
        end
    end

    // Only the highest-priority press of a cycle is acted upon.
    assign ev_clear  = clear_press_reg;
    assign ev_stop   = stop_press_reg  && !clear_press_reg;
    assign ev_start  = start_press_reg && !stop_press_reg && !clear_press_reg;
    assign ev_key    = key_press_reg   && !start_press_reg && !stop_press_reg && !clear_press_reg;
    assign any_press = clear_press_reg || stop_press_reg || start_press_reg || key_press_reg;

    assign tick         = (presc_reg == PRESC_LAST);
    assign digits_dec   = dec_time(digits_reg);
    assign digits_shift = {digits_reg[DW-BCD_W-1:0], key_val_reg};
    assign win_inc      = (win_reg == WIN_LAST) ? 4'd0 : win_reg + 4'd1;
    assign full_power   = (power_reg == 4'd0) || (power_reg > PWR_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            digits_reg      <= '0;
            presc_reg       <= '0;
            win_reg         <= 4'd0;
            power_reg       <= 4'd0;
            timer_done_reg  <= 1'b0;
            mag_term_reg    <= 1'b0;
            start_prev_reg  <= 1'b1;
            stop_prev_reg   <= 1'b1;
            clear_prev_reg  <= 1'b1;
            key_prev_reg    <= '0;
            start_press_reg <= 1'b0;
            stop_press_reg  <= 1'b0;
            clear_press_reg <= 1'b0;
            key_press_reg   <= 1'b0;
            key_val_reg     <= 4'd0;
        end else begin
            // Edge detection stage: a press seen on this edge acts on the next.
            start_prev_reg  <= startn;
            stop_prev_reg   <= stopn;
            clear_prev_reg  <= clearn;
            key_prev_reg    <= keypad;
            start_press_reg <= start_prev_reg && !startn;
            stop_press_reg  <= stop_prev_reg  && !stopn;
            clear_press_reg <= clear_prev_reg && !clearn;
            key_press_reg   <= key_single && (key_prev_reg == '0);
            key_val_reg     <= key_val;

            timer_done_reg  <= 1'b0;
            mag_term_reg    <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (ev_key) begin
                        state_reg  <= ST_ENTRY;
                        digits_reg <= digits_shift;
                    end
                end
                ST_ENTRY: begin
                    if (ev_clear) begin
                        state_reg  <= ST_IDLE;
                        digits_reg <= '0;
                    end else if (ev_start && door_closed && (digits_reg != '0)) begin
                        state_reg    <= ST_COOK;
                        presc_reg    <= '0;
                        win_reg      <= 4'd0;
                        power_reg    <= power_sel;
                        // Window 0 is always inside any legal duty window.
                        mag_term_reg <= 1'b1;
                    end else if (ev_key) begin
                        digits_reg <= digits_shift;
                    end
                end
                ST_COOK: begin
                    if (ev_clear) begin
                        state_reg  <= ST_IDLE;
                        digits_reg <= '0;
                    end else if (ev_stop || !door_closed) begin
                        state_reg <= ST_PAUSE;
                    end else if (tick) begin
                        presc_reg  <= '0;
                        digits_reg <= digits_dec;
                        win_reg    <= win_inc;
                        if (digits_dec == '0) begin
                            state_reg      <= ST_DONE;
                            timer_done_reg <= 1'b1;
                        end else begin
                            mag_term_reg <= duty_on(win_inc, power_reg, full_power);
                        end
                    end else begin
                        presc_reg    <= presc_reg + 1'b1;
                        mag_term_reg <= duty_on(win_reg, power_reg, full_power);
                    end
                end
                ST_PAUSE: begin
                    if (ev_clear || ev_stop) begin
                        state_reg  <= ST_IDLE;
                        digits_reg <= '0;
                    end else if (ev_start && door_closed) begin
                        state_reg    <= ST_COOK;
                        mag_term_reg <= duty_on(win_reg, power_reg, full_power);
                    end
                end
                ST_DONE: begin
                    if (any_press || !door_closed) begin
                        state_reg  <= ST_IDLE;
                        digits_reg <= '0;
                    end else begin
                        timer_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    digits_reg <= '0;
                end
            endcase
        end
    end

    assign digits       = digits_reg;
    assign state        = state_reg;
    assign timer_done   = timer_done_reg;
    // Door opening kills heating immediately, not a cycle later.
    assign magnetron_on = mag_term_reg && door_closed;

`ifdef MW_SEG_DECODE_EN
    generate
        genvar gi;
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
            mw_seg7 u_seg7 (
                .bcd (digits_reg[gi*BCD_W +: BCD_W]),
                .seg (seg[gi*7 +: 7])
            );
        end
    endgenerate
`else
    assign seg = '0;
`endif

endmodule
